// File: rtl/udp_traffic_gen_pkg.sv
// Shared types and constants for the UDP traffic generator: FSM states, the sequence-field
// width and the payload byte pattern.
package udp_traffic_gen_pkg;

  localparam int         SEQ_BYTES = 4;
  localparam logic [7:0] IP_TTL    = 8'd64;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    GAP
  } state_e;

  // The first SEQ_BYTES bytes carry the sequence number MSB first; after that each byte is its own index.
  function automatic logic [7:0] payload_byte(input logic [31:0] seq, input logic [15:0] idx);
    logic [7:0] b;
    b = idx[7:0];
    if (idx < 16'(SEQ_BYTES)) begin
      case (idx[1:0])
        2'd0:    b = seq[31:24];
        2'd1:    b = seq[23:16];
        2'd2:    b = seq[15:8];
        default: b = seq[7:0];
      endcase
    end
    return b;
  endfunction

endpackage

// File: rtl/AXIS_IF.sv
// Minimal AXI-Stream bundle with a one-bit tuser.
interface AXIS_IF #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport Transmitter (output tdata, tvalid, tlast, tuser, input tready);
  modport Receiver    (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/UDP_RX_HEADER_IF.sv
// UDP receive header bundle: valid/ready handshake plus the decoded address and port fields.
interface UDP_RX_HEADER_IF;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;
  logic [15:0] checksum;

  modport Source (
    output hdr_valid, ip_source_ip, ip_dest_ip, source_port, dest_port, length, checksum,
    input  hdr_ready
  );
  modport Sink (
    input  hdr_valid, ip_source_ip, ip_dest_ip, source_port, dest_port, length, checksum,
    output hdr_ready
  );
endinterface

// File: rtl/UDP_TX_HEADER_IF.sv
// UDP transmit header bundle: valid/ready handshake plus the IP and UDP header fields.
interface UDP_TX_HEADER_IF;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [5:0]  ip_dscp;
  logic [1:0]  ip_ecn;
  logic [7:0]  ip_ttl;
  logic [31:0] ip_source_ip;
  logic [31:0] ip_dest_ip;
  logic [15:0] source_port;
  logic [15:0] dest_port;
  logic [15:0] length;
  logic [15:0] checksum;

  modport Source (
    output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
    input  hdr_ready
  );
  modport Sink (
    input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
           source_port, dest_port, length, checksum,
    output hdr_ready
  );
endinterface

// File: rtl/udp_traffic_gen.sv
// UDP packet generator: a fixed header, then a sequence-numbered payload, then an optional idle gap.
// Build option: define UDP_TRAFFIC_GEN_RX_COUNT_EN to count received payload packets.
module udp_traffic_gen
  import udp_traffic_gen_pkg::*;
#(
  parameter int          UDP_PORT    = 1234,
  parameter int          DEST_PORT   = 5678,
  parameter logic [31:0] SOURCE_IP   = {8'd192, 8'd168, 8'd1, 8'd128},
  parameter logic [31:0] DEST_IP     = {8'd192, 8'd168, 8'd1, 8'd2},
  parameter int          PAYLOAD_LEN = 16,
  parameter int          GAP_CYCLES  = 0
) (
  input  logic                clk,
  input  logic                reset,
  UDP_TX_HEADER_IF.Source     udp_tx_header_if,
  AXIS_IF.Transmitter         udp_tx_payload_if,
  UDP_RX_HEADER_IF.Sink       udp_rx_header_if,
  AXIS_IF.Receiver            udp_rx_payload_if,
  input  logic                enable,
  output logic                busy,
  output logic [31:0]         tx_packet_count,
  output logic [31:0]         rx_packet_count
);

  localparam logic [15:0] LEN      = 16'(PAYLOAD_LEN);
  localparam logic [15:0] LAST_IDX = 16'(PAYLOAD_LEN - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [7:0]  tdata_q, tdata_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;
  logic [31:0] gap_q, gap_d;
  logic [15:0] next_idx;

  assign next_idx = idx_q + 16'd1;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    hdr_valid_d = hdr_valid_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    idx_d       = idx_q;
    seq_d       = seq_q;
    tx_cnt_d    = tx_cnt_q;
    gap_d       = gap_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = HDR;
          hdr_valid_d = 1'b1;
        end
      end
      HDR: begin
        // hdr_valid_q is always high here, so hdr_ready alone completes the handshake.
        if (udp_tx_header_if.hdr_ready) begin
          state_d     = PAYLOAD;
          hdr_valid_d = 1'b0;
          tvalid_d    = 1'b1;
          idx_d       = 16'd0;
          tdata_d     = payload_byte(seq_q, 16'd0);
          tlast_d     = (LAST_IDX == 16'd0);
        end
      end
      PAYLOAD: begin
        if (udp_tx_payload_if.tready) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            seq_d    = seq_q + 32'd1;
            tx_cnt_d = tx_cnt_q + 32'd1;
            gap_d    = 32'd0;
            state_d  = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            idx_d   = next_idx;
            tdata_d = payload_byte(seq_q, next_idx);
            tlast_d = (next_idx == LAST_IDX);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_d = IDLE;
        else                   gap_d   = gap_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge and clears every control flop, so a packet in
  // flight is dropped outright and tvalid is low the cycle after reset is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr_valid_q <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= 8'd0;
      idx_q       <= 16'd0;
      seq_q       <= 32'd0;
      tx_cnt_q    <= 32'd0;
      gap_q       <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      hdr_valid_q <= hdr_valid_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      idx_q       <= idx_d;
      seq_q       <= seq_d;
      tx_cnt_q    <= tx_cnt_d;
      gap_q       <= gap_d;
    end
  end

  assign busy            = (state_q != IDLE);
  assign tx_packet_count = tx_cnt_q;

  assign udp_tx_header_if.hdr_valid    = hdr_valid_q;
  assign udp_tx_header_if.ip_dscp      = 6'd0;
  assign udp_tx_header_if.ip_ecn       = 2'd0;
  assign udp_tx_header_if.ip_ttl       = IP_TTL;
  assign udp_tx_header_if.ip_source_ip = SOURCE_IP;
  assign udp_tx_header_if.ip_dest_ip   = DEST_IP;
  assign udp_tx_header_if.source_port  = 16'(UDP_PORT);
  assign udp_tx_header_if.dest_port    = 16'(DEST_PORT);
  assign udp_tx_header_if.length       = LEN;
  assign udp_tx_header_if.checksum     = 16'd0;

  assign udp_tx_payload_if.tdata  = tdata_q;
  assign udp_tx_payload_if.tvalid = tvalid_q;
  assign udp_tx_payload_if.tlast  = tlast_q;
  assign udp_tx_payload_if.tuser  = 1'b0;

  assign udp_rx_header_if.hdr_ready = 1'b1;
  assign udp_rx_payload_if.tready   = 1'b1;

`ifdef UDP_TRAFFIC_GEN_RX_COUNT_EN
  logic [31:0] rx_cnt_q, rx_cnt_d;

  // tready is tied high, so tvalid & tlast is the end-of-packet handshake.
  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (udp_rx_payload_if.tvalid && udp_rx_payload_if.tlast) rx_cnt_d = rx_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) rx_cnt_q <= 32'd0;
    else       rx_cnt_q <= rx_cnt_d;
  end

  assign rx_packet_count = rx_cnt_q;
`else
  assign rx_packet_count = 32'd0;
`endif

  // The receive side is a sink only; its content is deliberately ignored.
  logic unused_rx;
  assign unused_rx = ^{udp_rx_header_if.hdr_valid, udp_rx_header_if.ip_source_ip,
                       udp_rx_header_if.ip_dest_ip, udp_rx_header_if.source_port,
                       udp_rx_header_if.dest_port, udp_rx_header_if.length,
                       udp_rx_header_if.checksum, udp_rx_payload_if.tdata,
                       udp_rx_payload_if.tuser, udp_rx_payload_if.tvalid,
                       udp_rx_payload_if.tlast};

endmodule

// File: tb/tb_udp_traffic_gen.sv
// Scoreboard bench for udp_traffic_gen: dut0 (8-byte payload, no gap) carries most scenarios,
// dut1 (8-byte payload, 5-cycle gap) covers the idle gap.
module tb_udp_traffic_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        enable0, enable1;
  logic        busy0, busy1;
  logic [31:0] tx0, rx0, tx1, rx1;

  UDP_TX_HEADER_IF th0 ();
  UDP_TX_HEADER_IF th1 ();
  AXIS_IF #(.DATA_WIDTH(8)) tp0 ();
  AXIS_IF #(.DATA_WIDTH(8)) tp1 ();
  UDP_RX_HEADER_IF rh0 ();
  UDP_RX_HEADER_IF rh1 ();
  AXIS_IF #(.DATA_WIDTH(8)) rp0 ();
  AXIS_IF #(.DATA_WIDTH(8)) rp1 ();

  udp_traffic_gen #(.PAYLOAD_LEN(8), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .udp_tx_header_if(th0), .udp_tx_payload_if(tp0),
    .udp_rx_header_if(rh0), .udp_rx_payload_if(rp0),
    .enable(enable0), .busy(busy0),
    .tx_packet_count(tx0), .rx_packet_count(rx0)
  );

  udp_traffic_gen #(.PAYLOAD_LEN(8), .GAP_CYCLES(5)) dut1 (
    .clk(clk), .reset(reset),
    .udp_tx_header_if(th1), .udp_tx_payload_if(tp1),
    .udp_rx_header_if(rh1), .udp_rx_payload_if(rp1),
    .enable(enable1), .busy(busy1),
    .tx_packet_count(tx1), .rx_packet_count(rx1)
  );

  // ttl, dscp, ecn, source IP, dest IP, source port, dest port, length, checksum
  localparam logic [143:0] EXP_HDR = {8'd64, 6'd0, 2'd0, 32'hC0A8_0180, 32'hC0A8_0102,
                                      16'd1234, 16'd5678, 16'd8, 16'd0};
`ifdef UDP_TRAFFIC_GEN_RX_COUNT_EN
  localparam logic [31:0] EXP_RX = 32'd3;
`else
  localparam logic [31:0] EXP_RX = 32'd0;
`endif

  int checks = 0;
  int failures = 0;

  logic [143:0] exp_hdr_q[$];
  logic [9:0]   exp_byte_q[$];   // {tuser, tlast, tdata}
  int           bytes_seen = 0;
  int           hdr_seen = 0;
  bit           sb_en = 1'b1;
  bit           stall_pend = 1'b0;
  logic [8:0]   stall_val;

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_pkt(input logic [7:0] seq_lo);
    logic [7:0] pl [8];
    pl = '{8'h00, 8'h00, 8'h00, seq_lo, 8'h04, 8'h05, 8'h06, 8'h07};
    exp_hdr_q.push_back(EXP_HDR);
    for (int i = 0; i < 8; i++) exp_byte_q.push_back({1'b0, (i == 7), pl[i]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (bytes_seen < n && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    check({name, "_done"}, 160'(bytes_seen >= n), 160'd1);
  endtask

  // Monitor: handshakes on dut0 are compared against the queues on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (th0.hdr_valid && th0.hdr_ready) begin
        hdr_seen++;
        if (sb_en) begin
          check("hdr_expected", 160'(exp_hdr_q.size() != 0), 160'd1);
          if (exp_hdr_q.size() != 0)
            check("hdr_fields",
                  {th0.ip_ttl, th0.ip_dscp, th0.ip_ecn, th0.ip_source_ip, th0.ip_dest_ip,
                   th0.source_port, th0.dest_port, th0.length, th0.checksum},
                  exp_hdr_q.pop_front());
        end
      end
      if (stall_pend && sb_en)
        check("stall_hold", {tp0.tvalid, tp0.tlast, tp0.tdata}, {1'b1, stall_val});
      stall_pend = tp0.tvalid && !tp0.tready;
      stall_val  = {tp0.tlast, tp0.tdata};
      if (tp0.tvalid && tp0.tready) begin
        bytes_seen++;
        if (sb_en) begin
          check("byte_expected", 160'(exp_byte_q.size() != 0), 160'd1);
          if (exp_byte_q.size() != 0)
            check("payload_byte", {tp0.tuser, tp0.tlast, tp0.tdata}, exp_byte_q.pop_front());
        end
      end
    end else begin
      stall_pend = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int base;
    int bcnt;
    bit found;
    bit tv_in_gap;

    reset   = 1'b1;
    enable0 = 1'b0;
    enable1 = 1'b0;
    th0.hdr_ready = 1'b1;
    th1.hdr_ready = 1'b1;
    tp0.tready = 1'b1;
    tp1.tready = 1'b1;
    rh0.hdr_valid = 1'b0;
    rh1.hdr_valid = 1'b0;
    rp0.tvalid = 1'b0; rp0.tlast = 1'b0; rp0.tdata = 8'd0; rp0.tuser = 1'b0;
    rp1.tvalid = 1'b0; rp1.tlast = 1'b0; rp1.tdata = 8'd0; rp1.tuser = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_tvalid", 160'(tp0.tvalid), 160'd0);
    check("rst_tlast", 160'(tp0.tlast), 160'd0);
    check("rst_hdr_valid", 160'(th0.hdr_valid), 160'd0);
    check("rst_busy", 160'(busy0), 160'd0);
    check("rst_tx_count", 160'(tx0), 160'd0);
    check("rst_rx_count", 160'(rx0), 160'd0);
    check("rx_ready_tied", 160'({rh0.hdr_ready, rp0.tready}), 160'd3);

    // Single packet from one enable pulse.
    push_pkt(8'h00);
    enable0 = 1'b1;
    tick();
    enable0 = 1'b0;
    wait_bytes(8, 40, "t1");
    tick();
    tick();
    check("t1_tx_count", 160'(tx0), 160'd1);
    check("t1_busy", 160'(busy0), 160'd0);

    // Back-to-back packets with enable held: two idle-bus cycles (IDLE, HDR) between them.
    push_pkt(8'h01);
    push_pkt(8'h02);
    enable0 = 1'b1;
    wait_bytes(16, 60, "t2a");
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (tp0.tvalid) break;
      gap++;
    end
    check("b2b_gap", 160'(gap), 160'd2);
    wait_bytes(19, 40, "t2b");
    tick();
    enable0 = 1'b0;
    wait_bytes(24, 40, "t2c");
    repeat (5) tick();
    check("t2_tx_count", 160'(tx0), 160'd3);
    check("t2_hdr_count", 160'(hdr_seen), 160'd3);

    // Backpressure: tready toggles every cycle.
    push_pkt(8'h03);
    enable0 = 1'b1;
    tick();
    enable0 = 1'b0;
    for (int i = 0; i < 100 && bytes_seen < 32; i++) begin
      tp0.tready = ~tp0.tready;
      tick();
    end
    tp0.tready = 1'b1;
    check("t3_done", 160'(bytes_seen >= 32), 160'd1);
    repeat (3) tick();
    check("t3_tx_count", 160'(tx0), 160'd4);

    // Enable dropped while byte 3 is on the bus: packet completes, nothing follows.
    push_pkt(8'h04);
    enable0 = 1'b1;
    wait_bytes(35, 40, "t4a");
    tick();
    enable0 = 1'b0;
    wait_bytes(40, 40, "t4b");
    repeat (20) tick();
    check("t4_hdr_count", 160'(hdr_seen), 160'd5);
    check("t4_tx_count", 160'(tx0), 160'd5);
    check("t4_busy", 160'(busy0), 160'd0);

    // Reset while byte 3 is on the bus.
    sb_en = 1'b0;
    enable0 = 1'b1;
    wait_bytes(43, 40, "t5");
    tick();
    check("t5_pre_tvalid", 160'(tp0.tvalid), 160'd1);
    reset = 1'b1;
    enable0 = 1'b0;
    tick();
    check("t5_tvalid", 160'(tp0.tvalid), 160'd0);
    check("t5_tx_count", 160'(tx0), 160'd0);
    check("t5_busy", 160'(busy0), 160'd0);
    reset = 1'b0;
    tick();
    tick();
    check("t5_idle", 160'({tp0.tvalid, th0.hdr_valid}), 160'd0);
    sb_en = 1'b1;

    // After reset the sequence number restarts at zero.
    base = bytes_seen;
    push_pkt(8'h00);
    enable0 = 1'b1;
    tick();
    enable0 = 1'b0;
    wait_bytes(base + 8, 40, "t6");
    repeat (3) tick();
    check("t6_tx_count", 160'(tx0), 160'd1);

    // Gap: dut1 stays busy for exactly 5 cycles after the tlast handshake.
    enable1 = 1'b1;
    tick();
    enable1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (tp1.tvalid && tp1.tready && tp1.tlast) found = 1'b1;
    end
    check("t7_tlast_seen", 160'(found), 160'd1);
    bcnt = 0;
    tv_in_gap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!busy1) break;
      if (tp1.tvalid) tv_in_gap = 1'b1;
      bcnt++;
    end
    check("t7_gap_cycles", 160'(bcnt), 160'd5);
    check("t7_gap_quiet", 160'(tv_in_gap), 160'd0);
    check("t7_tx_count", 160'(tx1), 160'd1);

    // Receive side: three 2-beat packets, plus tlast without tvalid which must not count.
    tick();
    for (int p = 0; p < 3; p++) begin
      rp0.tvalid = 1'b1;
      rp0.tlast  = 1'b0;
      rp0.tdata  = 8'(p);
      tick();
      rp0.tlast = 1'b1;
      tick();
      rp0.tvalid = 1'b0;
      tick();
      rp0.tlast = 1'b0;
    end
    tick();
    check("rx_count", 160'(rx0), 160'(EXP_RX));

    check("hdr_queue_empty", 160'(exp_hdr_q.size()), 160'd0);
    check("byte_queue_empty", 160'(exp_byte_q.size()), 160'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_traffic_gen.md
UDP_TRAFFIC_GEN -- requirements
Module: udp_traffic_gen

Interface
REQ-001 SHALL have parameter UDP_PORT, default 1234: UDP source port.
REQ-002 SHALL have parameter DEST_PORT, default 5678: UDP destination port.
REQ-003 SHALL have parameter SOURCE_IP, default 192.168.1.128: IPv4 source address, 32 bits.
REQ-004 SHALL have parameter DEST_IP, default 192.168.1.2: IPv4 destination address, 32 bits.
REQ-005 SHALL have parameter PAYLOAD_LEN, default 16: payload bytes per packet; legal range 4..65507.
REQ-006 SHALL have parameter GAP_CYCLES, default 0: idle cycles after each packet; 0 is legal.
REQ-007 SHALL have port clk, input, 1: the single clock.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port udp_tx_header_if, UDP_TX_HEADER_IF.Source: outgoing header.
REQ-010 SHALL have port udp_tx_payload_if, AXIS_IF.Transmitter, 8-bit tdata: outgoing payload.
REQ-011 SHALL have port udp_rx_header_if, UDP_RX_HEADER_IF.Sink: incoming header.
REQ-012 SHALL have port udp_rx_payload_if, AXIS_IF.Receiver: incoming payload.
REQ-013 SHALL have port enable, input, 1: permits new packets to start.
REQ-014 SHALL have port busy, output, 1: high while state is not IDLE.
REQ-015 SHALL have port tx_packet_count, output, 32: number of completed TX packets.
REQ-016 SHALL have port rx_packet_count, output, 32: number of received payload packets.

Function
REQ-017 SHALL use FSM IDLE -> HDR -> PAYLOAD -> GAP -> IDLE; GAP SHALL be skipped when GAP_CYCLES=0.
REQ-018 SHALL go IDLE->HDR on the cycle after enable is sampled high in IDLE; hdr_valid SHALL be registered and high only in HDR.
REQ-019 SHALL hold header constant while hdr_valid=1: dscp=0, ecn=0, ttl=64, source/dest IP and ports from parameters, length=PAYLOAD_LEN, checksum=0.
REQ-020 SHALL go HDR->PAYLOAD on hdr_valid & hdr_ready; tvalid SHALL first be asserted the following cycle.
REQ-021 SHALL emit payload byte i as: i=0..3 the 32-bit sequence number, big-endian; i>=4 the value i[7:0].
REQ-022 SHALL hold tdata, tlast and tvalid stable while tvalid=1 and tready=0; tuser SHALL always be 0.
REQ-023 SHALL assert tlast only on byte PAYLOAD_LEN-1; the byte index counter SHALL advance only on tvalid & tready.
REQ-024 SHALL, on the final-byte handshake, increment the sequence number and tx_packet_count by 1, both wrapping at 2^32, and enter GAP (or IDLE).
REQ-025 SHALL stay in GAP for exactly GAP_CYCLES cycles, then go to IDLE.
REQ-026 SHALL NOT abort a packet in progress when enable falls; the packet completes and no new packet starts.
REQ-027 SHALL, when enable is held high with GAP_CYCLES=0 and always-ready sinks, return to HDR on the cycle after IDLE is re-entered.
REQ-028 SHALL tie udp_rx_header_if.hdr_ready=1 and udp_rx_payload_if.tready=1 at all times.

Reset
REQ-029 SHALL, on reset, force state=IDLE; hdr_valid, tvalid, tlast and busy=0; byte index, sequence number, tx_packet_count and rx_packet_count=0.
REQ-030 SHALL let reset asserted mid-packet drop the packet immediately, with tvalid=0 on the next cycle.

Configuration
REQ-031 SHALL, with UDP_TRAFFIC_GEN_RX_COUNT_EN defined, increment rx_packet_count (wrapping) on each rx tvalid & tlast handshake.
REQ-032 SHALL, without UDP_TRAFFIC_GEN_RX_COUNT_EN, tie rx_packet_count to 0 and contain no RX counter register.

Structure
REQ-033 SHALL place the FSM state enum and the sequence-field width constant (4 bytes) in package udp_traffic_gen_pkg.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 SHALL cover a single packet: PAYLOAD_LEN=8, enable pulsed, sinks ready -> header length=8, bytes 00 00 00 00 04 05 06 07, tlast on byte 7, tx_packet_count=1.
REQ-036 SHALL cover back-to-back packets: enable held, GAP_CYCLES=0 -> packet 2 starts with 00 00 00 01; consecutive packets are separated by exactly 2 non-payload cycles (IDLE, HDR).
REQ-037 SHALL cover backpressure: tready toggled 1/0 every cycle -> tdata and tlast stable while stalled; byte order unchanged.
REQ-038 SHALL cover the gap: GAP_CYCLES=5 -> exactly 5 GAP cycles after the tlast handshake, busy=1 throughout.
REQ-039 SHALL cover enable and reset mid-packet: enable dropped at byte 3 -> packet completes, no second header; reset at byte 3 -> tvalid=0 next cycle, counters 0.
REQ-040 SHALL cover RX counting: with UDP_TRAFFIC_GEN_RX_COUNT_EN defined, 3 RX packets -> rx_packet_count=3; without the macro -> rx_packet_count=0.
